// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: writes fill the back bank, reads scan the front bank, and the
// banks swap only on a display frame start. Define FRAME_BUFFER_CLEAR_EN to clear the new back bank.
module frame_buffer_pingpong #(
  parameter int unsigned       X_BITS      = 10,
  parameter int unsigned       Y_BITS      = 9,
  parameter int unsigned       PIX_W       = 3,
  parameter int unsigned       FRAME_W     = 640,
  parameter int unsigned       FRAME_H     = 480,
  parameter logic [PIX_W-1:0]  CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [X_BITS-1:0] write_x,
  input  logic [Y_BITS-1:0] write_y,
  input  logic [PIX_W-1:0]  write_data,
  input  logic              write_enable,
  output logic              write_ready,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              swap_done,
  input  logic              read_frame_start,
  input  logic [X_BITS-1:0] read_x,
  input  logic [Y_BITS-1:0] read_y,
  input  logic              read_enable,
  output logic [PIX_W-1:0]  read_data,
  output logic              read_valid,
  output logic              front_bank,
  output logic              clear_busy
);

  localparam int unsigned AddrW = 1 + X_BITS + Y_BITS;
  localparam int unsigned Depth = 1 << AddrW;
  localparam logic [X_BITS:0] FrameWExt = (X_BITS + 1)'(FRAME_W);
  localparam logic [Y_BITS:0] FrameHExt = (Y_BITS + 1)'(FRAME_H);

  typedef enum logic [1:0] {
`ifdef FRAME_BUFFER_CLEAR_EN
    StClear,
`endif
    StIdle,
    StPending
  } state_e;

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam state_e StAfterSwap = StClear;
`else
  localparam state_e StAfterSwap = StIdle;
`endif

  state_e state_q, state_d;
  logic   front_q;
  logic   swap_done_q;
  logic   swap_now;
  logic   clear_last;
  logic   req_latched_q;
  logic   [AddrW-1:0] clear_addr;

  logic [PIX_W-1:0] mem [Depth];
  logic [PIX_W-1:0] mem_q;
  logic             rd_v1_q, rd_oor1_q;
  logic [PIX_W-1:0] read_data_q;
  logic             read_valid_q;

  logic             wr_in_range, rd_in_range, wr_accept, rd_bank, we;
  logic [AddrW-1:0] waddr, raddr;
  logic [PIX_W-1:0] wdata;

  assign wr_in_range = ({1'b0, write_x} < FrameWExt) && ({1'b0, write_y} < FrameHExt);
  assign rd_in_range = ({1'b0, read_x} < FrameWExt) && ({1'b0, read_y} < FrameHExt);
  assign write_ready = (state_q == StIdle);
  assign wr_accept   = write_enable & write_ready & wr_in_range;

  always_comb begin
    state_d  = state_q;
    swap_now = 1'b0;
    case (state_q)
      StIdle: begin
        if (swap_req) begin
          if (read_frame_start) begin
            swap_now = 1'b1;
            state_d  = StAfterSwap;
          end else begin
            state_d = StPending;
          end
        end
      end
      StPending: begin
        if (read_frame_start) begin
          swap_now = 1'b1;
          state_d  = StAfterSwap;
        end
      end
`ifdef FRAME_BUFFER_CLEAR_EN
      StClear: begin
        if (clear_last) state_d = (req_latched_q || swap_req) ? StPending : StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      swap_done_q <= swap_now;
      if (swap_now) front_q <= ~front_q;
    end
  end

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam logic [X_BITS-1:0] XLast = X_BITS'(FRAME_W - 1);
  localparam logic [Y_BITS-1:0] YLast = Y_BITS'(FRAME_H - 1);

  logic [X_BITS-1:0] cx_q;
  logic [Y_BITS-1:0] cy_q;

  assign clear_busy = (state_q == StClear);
  assign clear_last = clear_busy && (cx_q == XLast) && (cy_q == YLast);
  assign clear_addr = {~front_q, cx_q, cy_q};

  // Counter idles at zero so every sweep starts from the first pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q          <= '0;
      cy_q          <= '0;
      req_latched_q <= 1'b0;
    end else if (!clear_busy) begin
      cx_q          <= '0;
      cy_q          <= '0;
      req_latched_q <= 1'b0;
    end else begin
      if (swap_req) req_latched_q <= 1'b1;
      if (cx_q == XLast) begin
        cx_q <= '0;
        cy_q <= cy_q + 1'b1;
      end else begin
        cx_q <= cx_q + 1'b1;
      end
    end
  end
`else
  assign clear_busy    = 1'b0;
  assign clear_last    = 1'b0;
  assign clear_addr    = '0;
  assign req_latched_q = 1'b0;
`endif

  assign swap_pending = (state_q == StPending) || (clear_busy && req_latched_q);

  // Reads sampled on a swap edge already target the new front bank.
  assign rd_bank = swap_now ? ~front_q : front_q;
  assign raddr   = {rd_bank, read_x, read_y};
  assign we      = wr_accept | clear_busy;
  assign waddr   = clear_busy ? clear_addr : {~front_q, write_x, write_y};
  assign wdata   = clear_busy ? CLEAR_VALUE : write_data;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    mem_q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_q      <= 1'b0;
      rd_oor1_q    <= 1'b0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      rd_v1_q      <= read_enable;
      rd_oor1_q    <= ~rd_in_range;
      read_valid_q <= rd_v1_q;
      if (rd_v1_q) read_data_q <= rd_oor1_q ? '0 : mem_q;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign front_bank = front_q;
  assign swap_done  = swap_done_q;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Directed bench for frame_buffer_pingpong; expectations follow FRAME_BUFFER_CLEAR_EN if defined.
module tb_frame_buffer_pingpong;

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif
  localparam logic [2:0] ClrVal = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] write_x, read_x;
  logic [1:0] write_y, read_y;
  logic [2:0] write_data, read_data;
  logic       write_enable, write_ready, swap_req, swap_pending, swap_done;
  logic       read_frame_start, read_enable, read_valid, front_bank, clear_busy;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  frame_buffer_pingpong #(
    .X_BITS(3), .Y_BITS(2), .PIX_W(3), .FRAME_W(6), .FRAME_H(3), .CLEAR_VALUE(ClrVal)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .write_x(write_x), .write_y(write_y), .write_data(write_data),
    .write_enable(write_enable), .write_ready(write_ready),
    .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
    .read_frame_start(read_frame_start), .read_x(read_x), .read_y(read_y),
    .read_enable(read_enable), .read_data(read_data), .read_valid(read_valid),
    .front_bank(front_bank), .clear_busy(clear_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] x, input logic [1:0] y, input logic [2:0] d);
    write_x = x; write_y = y; write_data = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [2:0] x, input logic [1:0] y,
                         input logic [2:0] exp);
    read_x = x; read_y = y; read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    chk({tag, "_lat1_valid"}, read_valid, 0);
    tick();
    chk({tag, "_valid"}, read_valid, 1);
    chk({tag, "_data"}, read_data, exp);
  endtask

  task automatic wait_clear();
    for (int i = 0; i < 50 && clear_busy; i++) tick();
    chk("clear_ends", clear_busy, 0);
  endtask

  function automatic logic [2:0] bank0_exp(input int x, input int y);
    if (x == 4 && y == 2) return 3'd3;
    return ClrEn ? ClrVal : 3'd0;
  endfunction

  initial begin
    rst_n = 1'b0;
    write_x = '0; write_y = '0; write_data = '0; write_enable = 1'b0;
    swap_req = 1'b0; read_frame_start = 1'b0;
    read_x = '0; read_y = '0; read_enable = 1'b0;
    #3;
    chk("rst_read_data", read_data, 0);
    chk("rst_read_valid", read_valid, 0);
    chk("rst_write_ready", write_ready, 1);
    chk("rst_swap_pending", swap_pending, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_front_bank", front_bank, 0);
    chk("rst_clear_busy", clear_busy, 0);
    #10 rst_n = 1'b1;
    tick();

    // Front bank 0 untouched before any swap.
    do_read("pre_swap_rd", 3'd2, 2'd1, 3'd0);
    do_write(3'd2, 2'd1, 3'd5);
    do_write(3'd7, 2'd1, 3'd3);
    do_write(3'd5, 2'd2, 3'd7);
    do_write(3'd0, 2'd0, 3'd1);
    do_write(3'd0, 2'd3, 3'd4);

    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("pend_set", swap_pending, 1);
    chk("pend_wready", write_ready, 0);
    chk("pend_front", front_bank, 0);
    do_write(3'd1, 2'd1, 3'd2);
    chk("pend_hold0", swap_pending, 1);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk($sformatf("pend_hold%0d", i), swap_pending, 1);
    end
    chk("pend_no_swap", swap_done, 0);

    // Swap with a read issued on the same edge: it must see the new front bank.
    read_frame_start = 1'b1; read_enable = 1'b1; read_x = 3'd2; read_y = 2'd1;
    tick();
    read_frame_start = 1'b0; read_enable = 1'b0;
    chk("swap1_done", swap_done, 1);
    chk("swap1_front", front_bank, 1);
    chk("swap1_pend", swap_pending, 0);
    chk("swap1_busy", clear_busy, ClrEn);
    chk("swap1_wready", write_ready, !ClrEn);
    chk("swap1_rv_lat1", read_valid, 0);
    n = clear_busy;
    tick();
    chk("swap1_done_pulse", swap_done, 0);
    chk("swap1_rd_valid", read_valid, 1);
    chk("swap1_rd_data", read_data, 5);
    n += clear_busy;
    for (int i = 0; i < 40 && clear_busy; i++) begin
      tick();
      n += clear_busy;
    end
    chk("clear_cycles", n, ClrEn ? 18 : 0);

    do_read("oor_rd", 3'd7, 2'd1, 3'd0);
    do_read("oor_y_rd", 3'd0, 2'd3, 3'd0);
    do_read("drop_pend_wr", 3'd1, 2'd1, 3'd0);
    do_read("edge_rd", 3'd5, 2'd2, 3'd7);
    do_read("origin_rd", 3'd0, 2'd0, 3'd1);
    tick();
    tick();
    chk("hold_valid", read_valid, 0);
    chk("hold_data", read_data, 1);

    do_write(3'd4, 2'd2, 3'd3);
    swap_req = 1'b1; read_frame_start = 1'b1;
    tick();
    swap_req = 1'b0; read_frame_start = 1'b0;
    chk("swap2_done", swap_done, 1);
    chk("swap2_front", front_bank, 0);
    chk("swap2_pend", swap_pending, 0);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("latched_req", swap_pending, 1);

    // Pipelined scan of every active pixel in bank 0.
    for (int i = 0; i <= 18; i++) begin
      if (i < 18) begin
        read_x = 3'(i % 6); read_y = 2'(i / 6); read_enable = 1'b1;
      end else begin
        read_enable = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("scan_v_%0d", i - 1), read_valid, 1);
        chk($sformatf("scan_d_%0d", i - 1), read_data, bank0_exp((i - 1) % 6, (i - 1) / 6));
      end
    end
    chk("scan_pend", swap_pending, 1);
    chk("scan_busy", clear_busy, 0);

    read_frame_start = 1'b1;
    tick();
    read_frame_start = 1'b0;
    chk("swap3_done", swap_done, 1);
    chk("swap3_front", front_bank, 1);
    chk("swap3_pend", swap_pending, 0);
    wait_clear();
    do_read("kept_21", 3'd2, 2'd1, ClrEn ? ClrVal : 3'd5);
    do_read("kept_52", 3'd5, 2'd2, ClrEn ? ClrVal : 3'd7);

    // Asynchronous reset while a swap is pending.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("rstp_pend_before", swap_pending, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstp_pend", swap_pending, 0);
    chk("rstp_front", front_bank, 0);
    chk("rstp_wready", write_ready, 1);
    chk("rstp_rdata", read_data, 0);
    chk("rstp_rvalid", read_valid, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("rstp_no_swap", swap_done, 0);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("rstp_req_pend", swap_pending, 1);
    chk("rstp_req_front", front_bank, 0);
    read_frame_start = 1'b1;
    tick();
    read_frame_start = 1'b0;
    chk("rstp_swap_front", front_bank, 1);
    chk("rstp_swap_done", swap_done, 1);
    chk("rstp_swap_busy", clear_busy, ClrEn);

    // Asynchronous reset during the clear sweep (or plain idle without it).
    #2 rst_n = 1'b0;
    #1;
    chk("rstc_busy", clear_busy, 0);
    chk("rstc_front", front_bank, 0);
    chk("rstc_done", swap_done, 0);
    chk("rstc_wready", write_ready, 1);
    #3 rst_n = 1'b1;
    tick();
    chk("rstc_idle_busy", clear_busy, 0);
    swap_req = 1'b1; read_frame_start = 1'b1;
    tick();
    swap_req = 1'b0; read_frame_start = 1'b0;
    chk("rstc_swap_front", front_bank, 1);
    chk("rstc_swap_done", swap_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
